// File: rtl/bc_fifo_arbiter_if.sv
// bc_fifo_arbiter_if: producer, FIFO and Avoidance-side signals of the breadcrumb FIFO arbiter
`timescale 1ns/1ps
interface bc_fifo_arbiter_if #(
    parameter int DW = 16
);
    logic          req0_valid;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          fifo_full;
    logic          fifo_wr_rst_busy;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          fifo_empty;
    logic          fifo_rd_rst_busy;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  fifo_full, fifo_wr_rst_busy, fifo_empty, fifo_rd_rst_busy, fifo_dout, out_ready,
        output req0_ready, req1_ready, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data
    );
    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        output fifo_full, fifo_wr_rst_busy, fifo_empty, fifo_rd_rst_busy, fifo_dout, out_ready,
        input  req0_ready, req1_ready, fifo_wr_en, fifo_din, fifo_rd_en, out_valid, out_data
    );
endinterface

// File: rtl/bc_fifo_arbiter.sv
// bc_fifo_arbiter: round-robin write arbiter and read sequencer for the breadcrumb FIFO.
// Define BC_ARB_STATS_EN to add saturating write/read/stall statistics counters.
`timescale 1ns/1ps
module bc_fifo_arbiter #(
    parameter int DW = 16
`ifdef BC_ARB_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    bc_fifo_arbiter_if.master bus,
    output logic              last_grant_o,
    output logic              init_done_o
`ifdef BC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  wr_cnt0_o,
    output logic [CNT_W-1:0]  wr_cnt1_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);
    typedef enum logic [1:0] {INIT, IDLE, WAIT, HOLD} state_e;
    state_e        state_q, state_d;
    logic          init_done_q, last_grant_q, grant, wr_ok;
    logic [DW-1:0] out_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            init_done_q <= init_done_q | (!bus.fifo_wr_rst_busy & !bus.fifo_rd_rst_busy);
            if (bus.fifo_wr_en) last_grant_q <= grant;
        end
    end

    // On a tie the producer that was not written last wins
    assign wr_ok          = init_done_q & !bus.fifo_full & !bus.fifo_wr_rst_busy;
    assign grant          = (bus.req0_valid & bus.req1_valid) ? !last_grant_q : bus.req1_valid;
    assign bus.fifo_wr_en = wr_ok & (grant ? bus.req1_valid : bus.req0_valid);
    assign bus.fifo_din   = grant ? bus.req1_data : bus.req0_data;
    assign bus.req0_ready = wr_ok & !grant & bus.req0_valid;
    assign bus.req1_ready = wr_ok & grant & bus.req1_valid;
    assign last_grant_o   = last_grant_q;
    assign init_done_o    = init_done_q;

    always_ff @(posedge clk) state_q <= rst ? INIT : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    state_d = init_done_q ? IDLE : INIT;
            IDLE:    state_d = (!bus.fifo_empty & !bus.fifo_rd_rst_busy) ? WAIT : IDLE;
            WAIT:    state_d = HOLD;
            HOLD:    state_d = !bus.out_ready ? HOLD : bus.fifo_empty ? IDLE : WAIT;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = (state_q == IDLE) ? (!bus.fifo_empty & !bus.fifo_rd_rst_busy)
                                           : ((state_q == HOLD) & bus.out_ready & !bus.fifo_empty);
        bus.out_valid  = state_q == HOLD;
    end

    // fifo_dout is valid during WAIT, one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (rst) out_data_q <= '0;
        else if (state_q == WAIT) out_data_q <= bus.fifo_dout;
    end
    assign bus.out_data = out_data_q;

`ifdef BC_ARB_STATS_EN
    logic [CNT_W-1:0] wr_cnt0_q, wr_cnt1_q, rd_cnt_q, stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt0_q   <= '0;
            wr_cnt1_q   <= '0;
            rd_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_cnt0_q   <= sat_inc(wr_cnt0_q, bus.req0_ready);
            wr_cnt1_q   <= sat_inc(wr_cnt1_q, bus.req1_ready);
            rd_cnt_q    <= sat_inc(rd_cnt_q, bus.out_valid & bus.out_ready);
            stall_cnt_q <= sat_inc(stall_cnt_q, (bus.req0_valid | bus.req1_valid) & bus.fifo_full);
        end
    end
    assign wr_cnt0_o   = wr_cnt0_q;
    assign wr_cnt1_o   = wr_cnt1_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule
